// File: rtl/iob_fp_acc_ctrl_pkg.sv
// Shared types and sizing helpers for the FP reduction controller.
package iob_fp_acc_pkg;

  // Controller phases: accept elements, drain partial sums, present result.
  typedef enum logic [1:0] {
    ACC   = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } acc_state_e;

  localparam int ADD_LAT_DEF = 5;

  // In-flight counter must reach ADD_LAT+1: an issue is counted one cycle
  // before the adder samples it.
  function automatic int cnt_width(input int lat);
    return $clog2(lat + 2);
  endfunction

  localparam int CNT_W = cnt_width(ADD_LAT_DEF);

endpackage

// File: rtl/iob_fp_acc_ctrl_if.sv
// Element stream, adder start/done and sum stream of the reduction controller.
interface iob_fp_acc_ctrl_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] data_i;
  logic              valid_i;
  logic              last_i;
  logic              ready_o;
  logic              add_start_o;
  logic [DATA_W-1:0] add_op_a_o;
  logic [DATA_W-1:0] add_op_b_o;
  logic              add_done_i;
  logic [DATA_W-1:0] add_res_i;
  logic [DATA_W-1:0] sum_o;
  logic              sum_valid_o;
  logic              sum_ready_i;
  logic              err_o;

  // Controller side.
  modport slave (
    input  data_i, valid_i, last_i, add_done_i, add_res_i, sum_ready_i,
    output ready_o, add_start_o, add_op_a_o, add_op_b_o, sum_o, sum_valid_o, err_o
  );

  // Environment side: element source, adder and sum consumer.
  modport master (
    output data_i, valid_i, last_i, add_done_i, add_res_i, sum_ready_i,
    input  ready_o, add_start_o, add_op_a_o, add_op_b_o, sum_o, sum_valid_o, err_o
  );
endinterface

// File: rtl/iob_fp_add.sv
// Pipelined FP adder: truncating, finite normal operands, fixed ADD_LAT latency.
module iob_fp_add #(
  parameter int DATA_W  = 32,
  parameter int EXP_W   = 8,
  parameter int ADD_LAT = 5
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  output logic              done_o,
  output logic [DATA_W-1:0] res_o
);
  localparam int MAN_W = DATA_W - EXP_W - 1;

  logic [DATA_W-1:0] big, sml, res_c;
  logic [EXP_W-1:0]  eb, es, ex;
  logic [MAN_W:0]    mb, ms, ms_al;
  logic [MAN_W+1:0]  acc;
  int                sh;
  int unsigned       pos, lz;

  logic [ADD_LAT-1:0] vld_q;
  logic [DATA_W-1:0]  res_q [ADD_LAT];

  // Align the smaller magnitude to the larger, add or subtract, renormalise.
  always_comb begin
    big = op_a_i;
    sml = op_b_i;
    if (op_b_i[DATA_W-2:0] > op_a_i[DATA_W-2:0]) begin
      big = op_b_i;
      sml = op_a_i;
    end
    eb    = big[DATA_W-2 -: EXP_W];
    es    = sml[DATA_W-2 -: EXP_W];
    mb    = {|eb, big[MAN_W-1:0]};
    ms    = {|es, sml[MAN_W-1:0]};
    sh    = int'(eb) - int'(es);
    ms_al = (sh > MAN_W) ? '0 : (ms >> sh);
    ex    = eb;
    pos   = 0;
    lz    = 0;
    if (big[DATA_W-1] == sml[DATA_W-1]) begin
      acc = {1'b0, mb} + {1'b0, ms_al};
      if (acc[MAN_W+1]) begin
        acc = acc >> 1;
        ex  = eb + 1'b1;
      end
    end else begin
      acc = {1'b0, mb} - {1'b0, ms_al};
      for (int unsigned k = 0; k <= MAN_W; k++) begin
        if (acc[k]) pos = k;
      end
      lz  = MAN_W - pos;
      acc = acc << lz;
      ex  = eb - EXP_W'(lz);
    end
    if (acc == '0) res_c = '0;
    else           res_c = {big[DATA_W-1], ex, acc[MAN_W-1:0]};
  end

  // Fixed-latency result pipeline; no backpressure.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < ADD_LAT; i++) res_q[i] <= '0;
    end else begin
      vld_q[0] <= start_i;
      res_q[0] <= res_c;
      for (int unsigned i = 1; i < ADD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        res_q[i] <= res_q[i-1];
      end
    end
  end

  assign done_o = vld_q[ADD_LAT-1];
  assign res_o  = res_q[ADD_LAT-1];

endmodule

// File: rtl/iob_fp_acc_ctrl.sv
// Streaming FP reduction controller: pairs elements and returning partial sums
// into adder issues and emits one sum per packet.
module iob_fp_acc_ctrl
  import iob_fp_acc_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int EXP_W   = 8,
  parameter int ADD_LAT = ADD_LAT_DEF
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  iob_fp_acc_ctrl_if.slave bus
);
  localparam int CW = cnt_width(ADD_LAT);

  if (EXP_W < 2 || EXP_W > DATA_W - 3) begin : g_exp_w_chk
    $error("iob_fp_acc_ctrl: EXP_W out of range for DATA_W");
  end

  acc_state_e        state_q;
  logic              ready_q;
  logic              start_q;
  logic [DATA_W-1:0] op_a_q, op_b_q;
  logic [DATA_W-1:0] h_q;
  logic              h_vld_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] sum_q;
  logic              sum_vld_q;
  logic              err_q;

  logic              r_vld, i_vld, drop, issue;
  logic [DATA_W-1:0] op_a_d, op_b_d, h_d;
  logic              h_vld_d;
  logic [CW-1:0]     cnt_d;

  // Operand pairing: a returning result is always consumed; at most one issue.
  always_comb begin
    r_vld   = bus.add_done_i && (cnt_q != '0);
    drop    = bus.add_done_i && (cnt_q == '0);
    i_vld   = bus.valid_i && ready_q;
    issue   = 1'b0;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    h_d     = h_q;
    h_vld_d = h_vld_q;
    if (r_vld && i_vld) begin
      issue  = 1'b1;
      op_a_d = bus.add_res_i;
      op_b_d = bus.data_i;
    end else if (r_vld && h_vld_q) begin
      issue   = 1'b1;
      op_a_d  = bus.add_res_i;
      op_b_d  = h_q;
      h_vld_d = 1'b0;
    end else if (r_vld) begin
      h_d     = bus.add_res_i;
      h_vld_d = 1'b1;
    end else if (i_vld && h_vld_q) begin
      issue   = 1'b1;
      op_a_d  = h_q;
      op_b_d  = bus.data_i;
      h_vld_d = 1'b0;
    end else if (i_vld) begin
      h_d     = bus.data_i;
      h_vld_d = 1'b1;
    end
    cnt_d = cnt_q;
    if (issue && !r_vld)      cnt_d = cnt_q + 1'b1;
    else if (!issue && r_vld) cnt_d = cnt_q - 1'b1;
  end

  // Phase FSM with registered outputs; the DRAIN exit overrides the hold update.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q   <= ACC;
      ready_q   <= 1'b0;
      start_q   <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      h_q       <= '0;
      h_vld_q   <= 1'b0;
      cnt_q     <= '0;
      sum_q     <= '0;
      sum_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      start_q <= issue;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      h_q     <= h_d;
      h_vld_q <= h_vld_d;
      cnt_q   <= cnt_d;
      if (drop) err_q <= 1'b1;
      case (state_q)
        ACC: begin
          if (i_vld && bus.last_i) begin
            state_q <= DRAIN;
            ready_q <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (cnt_q == '0 && !bus.add_done_i && h_vld_q) begin
            sum_q     <= h_q;
            sum_vld_q <= 1'b1;
            h_vld_q   <= 1'b0;
            state_q   <= OUT;
          end
        end
        OUT: begin
          if (bus.sum_ready_i) begin
            sum_vld_q <= 1'b0;
            ready_q   <= 1'b1;
            state_q   <= ACC;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

  assign bus.ready_o     = ready_q;
  assign bus.add_start_o = start_q;
  assign bus.add_op_a_o  = op_a_q;
  assign bus.add_op_b_o  = op_b_q;
  assign bus.sum_o       = sum_q;
  assign bus.sum_valid_o = sum_vld_q;
  assign bus.err_o       = err_q;

endmodule

// File: doc/iob_fp_acc_ctrl.md
Name: iob_fp_acc_ctrl

Overview:
- Streaming floating-point reduction controller placed directly upstream of the pipelined FP adder (iob_fp_add).
- Accepts a packet of FP words on a valid/ready stream and issues operand pairs to the adder via its start/done interface.
- Recirculates adder results as partial sums and emits one FP sum per packet.
- Never stalls the adder, which has no backpressure.

Parameters:
- DATA_W, 32, FP word width.
- EXP_W, 8, exponent width; passed through for width checks only.
- ADD_LAT, 5, adder latency in cycles, from start_o sampled to done_i; sizes the in-flight counter.

Ports:
- clk_i  in  1  clock
- arst_n_i  in  1  asynchronous active-low reset
- data_i  in  DATA_W  input element
- valid_i  in  1  element valid
- last_i  in  1  final element of packet; qualified by valid_i & ready_o
- ready_o  out  1  element accepted when valid_i & ready_o
- add_start_o  out  1  one-cycle issue pulse to adder
- add_op_a_o  out  DATA_W  adder operand A
- add_op_b_o  out  DATA_W  adder operand B
- add_done_i  in  1  adder result valid, one cycle
- add_res_i  in  DATA_W  adder result
- sum_o  out  DATA_W  packet sum
- sum_valid_o  out  1  sum valid
- sum_ready_i  in  1  sum consumed
- err_o  out  1  sticky: add_done_i seen with zero adds in flight

Behaviour:
- Reset (async, arst_n_i=0):
  - All outputs 0, state ACC, hold register empty, in-flight count 0.
  - Reset mid-packet discards all partial sums.
  - Results returning after reset are flagged by err_o and dropped.
- Outputs:
  - add_start_o, add_op_a_o, add_op_b_o, sum_o and sum_valid_o are registered.
  - Operands hold their value between issues.
- Operand sources each cycle:
  - R = add_done_i.
  - I = valid_i & ready_o.
  - H = hold register valid.
- Pairing priority, evaluated every cycle:
  - R&I: issue (res, data); H unchanged.
  - R&H, no I: issue (res, H); H emptied.
  - R only: H <= res.
  - I&H, no R: issue (H, data); H emptied.
  - I only: H <= data.
  - None: idle.
  - R is therefore always consumed. At most one issue per cycle.
- In-flight counter:
  - Counts +1 on issue and -1 on add_done_i; simultaneous issue and done leaves it unchanged.
  - Width is clog2(ADD_LAT+2).
  - add_done_i with count 0 sets err_o, and the result is dropped.
- FSM:
  - ACC: ready_o=1. On an accepted element with last_i=1, go to DRAIN.
  - DRAIN: ready_o=0. Pairing continues. When count==0, add_done_i=0 and H valid, load sum_o<=H, clear H, assert sum_valid_o, go to OUT.
  - OUT: ready_o=0. Hold sum_o and sum_valid_o until sum_ready_i, then return to ACC with ready_o=1 on the next cycle.
- Single-element packet (first element has last_i): the element goes to H, then DRAIN, and is output unchanged with no adder issue.
- Latency:
  - Single-element packet: sum_valid_o asserts 2 cycles after acceptance.
  - N-element back-to-back packet: approximately ceil(log2 N)·(ADD_LAT+1) cycles after last, worst case.
- Summation order depends on arrival timing. The result is bit-exact only for exactly representable sums; the bench uses integer-valued inputs.
- No special-case handling of NaN or Inf; the adder's behaviour applies.

Decomposition:
- Package iob_fp_acc_pkg holds:
  - FSM state encodings ACC/DRAIN/OUT (2 bits).
  - CNT_W = clog2(ADD_LAT+2).
- Single flat module; no sub-module.
- The bench instantiates iob_fp_add with ADD_LAT=5, with add_start_o→start_i, add_op_a_o→op_a_i, add_op_b_o→op_b_i, done_o→add_done_i and res_o→add_res_i.

Test Plan:
- Single element: 0x40400000 (3.0) with last_i -> sum_o=0x40400000, sum_valid_o 2 cycles later, add_start_o never asserted.
- Back-to-back 1.0, 2.0, 3.0, 4.0 (0x3F800000, 0x40000000, 0x40400000, 0x40800000), last on 4.0 -> sum_o=0x41200000 (10.0); exactly 3 add_start_o pulses.
- 100 × 1.0 with random valid_i gaps -> sum_o=0x42C80000 (100.0); 99 issues, err_o=0, in-flight never exceeds ADD_LAT.
- sum_ready_i held low for 20 cycles, with the next packet presented during that time -> ready_o=0 and sum_o stable throughout; the next packet is accepted the cycle after the handshake, and its sum is correct.
- Async reset asserted mid-DRAIN with 3 adds in flight -> outputs 0 immediately; the 3 later add_done_i pulses set err_o=1; a following packet 2.0+2.0 yields 0x40800000.
- Spurious add_done_i in idle ACC -> err_o=1 (sticky), H unchanged, no issue.
